// File: rtl/dm_sb_pkg.sv
// Shared types and helpers for the DM posted-write store buffer.
package dm_sb_pkg;

    localparam int unsigned SB_DEPTH = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [31:0] pc;
    } sb_entry_t;

    // Byte address to word index; the shift keeps every input bit referenced.
    function automatic logic [29:0] word_idx(input logic [31:0] byte_addr);
        return 30'(byte_addr >> 2);
    endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// Store, load-lookup and DM write-port signals between datapath, buffer and DM.
interface dm_store_buffer_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        dm_WE;
    logic [31:0] dm_adress;
    logic [31:0] dm_Wdata;
    logic [31:0] dm_pc;

    modport master (
        output st_valid, st_addr, st_data, st_pc, ld_req, ld_addr,
        input  st_ready, ld_hit, ld_data, dm_WE, dm_adress, dm_Wdata, dm_pc
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_pc, ld_req, ld_addr,
        output st_ready, ld_hit, ld_data, dm_WE, dm_adress, dm_Wdata, dm_pc
    );
endinterface

// File: rtl/dm_sb_lookup.sv
// Youngest-match search over the store buffer entries for load forwarding.
module dm_sb_lookup
    import dm_sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic [29:0]      waddr [DEPTH],
    input  logic [31:0]      wdata [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [PTR_W-1:0] tail,
    input  logic [29:0]      key,
    output logic             hit,
    output logic [31:0]      data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest (tail) to youngest (tail-1); the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = tail + PTR_W'(k);
            if (valid[idx] && (waddr[idx] == key)) begin
                hit  = 1'b1;
                data = wdata[idx];
            end
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer in front of DM; drains in order, yields to loads.
// Optional build macro: STORE_BUF_COALESCE_EN merges a store into the youngest entry.
module dm_store_buffer
    import dm_sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    dm_store_buffer_if.slave sb,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    sb_entry_t        mem [DEPTH];
    logic [29:0]      waddr_a [DEPTH];
    logic [31:0]      wdata_a [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_prev;
    logic [PTR_W-1:0] off;
    logic [DEPTH-1:0] valid;
    logic [29:0]      st_widx;
    logic [29:0]      ld_widx;
    logic             full;
    logic             pop;
    logic             push;
    logic             alloc;
    logic             coal;

    assign st_widx   = word_idx(sb.st_addr);
    assign ld_widx   = word_idx(sb.ld_addr);
    assign tail_prev = tail - PTR_W'(1);
    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign pop       = !empty && !sb.ld_req;

`ifdef STORE_BUF_COALESCE_EN
    // Youngest entry is only being popped when it is also the head.
    assign coal = sb.st_valid && !empty && (mem[tail_prev].waddr == st_widx)
                  && !(pop && (count == (PTR_W+1)'(1)));
`else
    assign coal = 1'b0;
`endif

    assign sb.st_ready = !full || pop || coal;
    assign push        = sb.st_valid && sb.st_ready;
    assign alloc       = push && !coal;

    assign sb.dm_WE     = pop;
    assign sb.dm_adress = empty ? '0 : {mem[head].waddr, 2'b00};
    assign sb.dm_Wdata  = empty ? '0 : mem[head].data;
    assign sb.dm_pc     = empty ? '0 : mem[head].pc;

    // Valid mask: slots whose distance from head is below count.
    always_comb begin
        valid = '0;
        off   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - head;
            valid[i] = ((PTR_W+1)'(off) < count);
            waddr_a[i] = mem[i].waddr;
            wdata_a[i] = mem[i].data;
        end
    end

    dm_sb_lookup #(.DEPTH(DEPTH)) u_lookup (
        .waddr (waddr_a),
        .wdata (wdata_a),
        .valid (valid),
        .tail  (tail),
        .key   (ld_widx),
        .hit   (sb.ld_hit),
        .data  (sb.ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)   head <= head + PTR_W'(1);
            if (alloc) tail <= tail + PTR_W'(1);
            case ({alloc, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage is not reset; the valid mask guards every read.
    always_ff @(posedge clk) begin
        if (alloc) begin
            mem[tail].waddr <= st_widx;
            mem[tail].data  <= sb.st_data;
            mem[tail].pc    <= sb.st_pc;
        end
        if (push && coal) begin
            mem[tail_prev].data <= sb.st_data;
            mem[tail_prev].pc   <= sb.st_pc;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: queue model of buffered stores and DM drain order.
module tb_dm_store_buffer;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    logic       clk;
    logic       rst;
    logic       empty;
    logic [2:0] count;
    ent_t       exp_q[$];
    int         n_checks;
    int         n_fail;
    int         wr_cnt;

    dm_store_buffer_if sbif();

    dm_store_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .sb    (sbif),
        .empty (empty),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One clock: drive at negedge, compare against the model, update the model at posedge.
    task automatic cyc(input logic v, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [31:0] sp, input logic lr, input logic [31:0] la,
                       output logic acc);
        logic        m_pop, m_coal, m_ready, m_hit;
        logic [31:0] m_ld;
        ent_t        hd;
        int          n;
        @(negedge clk);
        sbif.st_valid = v;  sbif.st_addr = sa;  sbif.st_data = sd;  sbif.st_pc = sp;
        sbif.ld_req   = lr; sbif.ld_addr = la;
        #1;
        n      = exp_q.size();
        m_pop  = (n != 0) && !lr;
        m_coal = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
        if (v && n != 0 && exp_q[n-1].a[31:2] == sa[31:2] && !(m_pop && n == 1)) m_coal = 1'b1;
`endif
        m_ready = (n != 4) || m_pop || m_coal;
        m_hit = 1'b0;
        m_ld  = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (exp_q[i].a[31:2] == la[31:2]) begin
                m_hit = 1'b1;
                m_ld  = exp_q[i].d;
                break;
            end
        end
        hd = (n != 0) ? exp_q[0] : '{32'h0, 32'h0, 32'h0};
        if (n != 0) hd.a = {hd.a[31:2], 2'b00};
        n_checks += 9;
        if (count !== 3'(n)) begin n_fail++; $display("FAIL count: got %0d want %0d", count, n); end
        if (empty !== (n == 0)) begin n_fail++; $display("FAIL empty: got %b want %b", empty, n == 0); end
        if (sbif.st_ready !== m_ready) begin n_fail++; $display("FAIL st_ready: got %b want %b", sbif.st_ready, m_ready); end
        if (sbif.dm_WE !== m_pop) begin n_fail++; $display("FAIL dm_WE: got %b want %b", sbif.dm_WE, m_pop); end
        if (sbif.dm_adress !== hd.a) begin n_fail++; $display("FAIL dm_adress: got %h want %h", sbif.dm_adress, hd.a); end
        if (sbif.dm_Wdata !== hd.d) begin n_fail++; $display("FAIL dm_Wdata: got %h want %h", sbif.dm_Wdata, hd.d); end
        if (sbif.dm_pc !== hd.p) begin n_fail++; $display("FAIL dm_pc: got %h want %h", sbif.dm_pc, hd.p); end
        if (sbif.ld_hit !== m_hit) begin n_fail++; $display("FAIL ld_hit @%h: got %b want %b", la, sbif.ld_hit, m_hit); end
        if (sbif.ld_data !== m_ld) begin n_fail++; $display("FAIL ld_data @%h: got %h want %h", la, sbif.ld_data, m_ld); end
        if (sbif.dm_WE === 1'b1) wr_cnt++;
        @(posedge clk);
        acc = v && m_ready;
        if (m_pop) void'(exp_q.pop_front());
        if (acc) begin
            if (m_coal) begin
                exp_q[exp_q.size()-1].d = sd;
                exp_q[exp_q.size()-1].p = sp;
            end else begin
                exp_q.push_back('{sa, sd, sp});
            end
        end
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc(1'b0, 0, 0, 0, 1'b0, 0, acc);
        #1;
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_reset();
        sbif.ld_addr = 32'h10;
        #1;
        n_checks += 5;
        if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
        if (sbif.dm_WE !== 1'b0) begin n_fail++; $display("FAIL rst_dm_WE: got %b want 0", sbif.dm_WE); end
        if (sbif.st_ready !== 1'b1) begin n_fail++; $display("FAIL rst_st_ready: got %b want 1", sbif.st_ready); end
        if ({sbif.ld_hit, sbif.ld_data} !== 33'h0) begin n_fail++; $display("FAIL rst_ld: got %b/%h want 0/0", sbif.ld_hit, sbif.ld_data); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic acc;
        cyc(1'b1, 32'h10, 32'h1234, 32'h400, 1'b0, 32'h10, acc);
        cyc(1'b0, 0, 0, 0, 1'b0, 32'h10, acc);
        drain();
    endtask

    task automatic test_backpressure();
        logic acc;
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(4*i), 32'hB0 + 32'(i), 32'h500 + 32'(4*i), 1'b1, 0, acc);
        cyc(1'b1, 32'h110, 32'hB4, 32'h510, 1'b1, 0, acc);
        #1;
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL bp_full_count: got %0d want 4", count); end
        cyc(1'b1, 32'h110, 32'hB4, 32'h510, 1'b0, 0, acc);
        #1;
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL bp_swap_count: got %0d want 4", count); end
        drain();
    endtask

    task automatic test_forwarding();
        logic acc;
        cyc(1'b1, 32'h20, 32'hAAAA, 32'h600, 1'b1, 0, acc);
        cyc(1'b1, 32'h24, 32'hBBBB, 32'h604, 1'b1, 0, acc);
        cyc(1'b1, 32'h20, 32'hCCCC, 32'h608, 1'b1, 32'h20, acc);
        cyc(1'b0, 0, 0, 0, 1'b1, 32'h22, acc);
        @(negedge clk);
        sbif.ld_addr = 32'h22;
        #1;
        n_checks += 2;
        if (sbif.ld_hit !== 1'b1) begin n_fail++; $display("FAIL fwd_hit: got %b want 1", sbif.ld_hit); end
        if (sbif.ld_data !== 32'hCCCC) begin n_fail++; $display("FAIL fwd_data: got %h want cccc", sbif.ld_data); end
        sbif.ld_addr = 32'h28;
        #1;
        n_checks += 2;
        if (sbif.ld_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_miss_hit: got %b want 0", sbif.ld_hit); end
        if (sbif.ld_data !== 32'h0) begin n_fail++; $display("FAIL fwd_miss_data: got %h want 0", sbif.ld_data); end
        drain();
    endtask

    task automatic test_order_wrap();
        logic acc;
        int   sent, start;
        sent  = 0;
        start = wr_cnt;
        for (int k = 0; k < 200 && sent < 10; k++) begin
            cyc(1'b1, 32'h200 + 32'(4*sent), $urandom, 32'h700 + 32'(4*sent),
                1'($urandom_range(0, 2) != 0), 32'h200 + 32'(4*$urandom_range(0, 9)), acc);
            if (acc) sent++;
        end
        drain();
        n_checks++;
        if (wr_cnt - start !== 10) begin n_fail++; $display("FAIL order_writes: got %0d want 10", wr_cnt - start); end
    endtask

    task automatic test_coalesce();
        logic acc;
        int   start, want_cnt;
`ifdef STORE_BUF_COALESCE_EN
        want_cnt = 1;
`else
        want_cnt = 2;
`endif
        cyc(1'b1, 32'h30, 32'h1, 32'h800, 1'b1, 0, acc);
        cyc(1'b1, 32'h30, 32'h2, 32'h804, 1'b1, 0, acc);
        #1;
        n_checks++;
        if (count !== 3'(want_cnt)) begin n_fail++; $display("FAIL coal_count: got %0d want %0d", count, want_cnt); end
        start = wr_cnt;
        drain();
        n_checks++;
        if (wr_cnt - start !== want_cnt) begin n_fail++; $display("FAIL coal_writes: got %0d want %0d", wr_cnt - start, want_cnt); end
    endtask

    task automatic test_reset_midrun();
        logic acc;
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h40 + 32'(4*i), 32'hD0 + 32'(i), 32'h900, 1'b1, 0, acc);
        @(negedge clk);
        sbif.st_valid = 1'b0;
        sbif.ld_req   = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks += 3;
        if (count !== 3'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
        if (sbif.dm_WE !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dm_WE: got %b want 0", sbif.dm_WE); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 0, 1'b0, 32'h40, acc);
        n_checks++;
        if (wr_cnt !== 0) begin n_fail++; $display("FAIL mid_rst_writes: got %0d want 0", wr_cnt); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wr_cnt   = 0;
        rst      = 1'b0;
        sbif.st_valid = 1'b0; sbif.st_addr = '0; sbif.st_data = '0; sbif.st_pc = '0;
        sbif.ld_req   = 1'b0; sbif.ld_addr = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_forwarding();
        test_order_wrap();
        test_coalesce();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-write store buffer between the datapath's memory stage and DM.
- Accepts word stores (sw), queues them in order, and drains one per cycle into DM's write port.
- Load lookups hit the buffer first, so loads see the buffered data.
- Drain yields to loads because DM has a single address port.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset; clears all state.
- st_valid  in  1  datapath presents a store this cycle.
- st_ready  out  1  store accepted this cycle when st_valid is also high.
- st_addr  in  32  store byte address; bits [1:0] ignored (word-aligned).
- st_data  in  32  store word.
- st_pc  in  32  PC of the store instruction; travels to DM for trace output.
- ld_req  in  1  datapath is using DM's address port for a load this cycle.
- ld_addr  in  32  load byte address; bits [1:0] ignored.
- ld_hit  out  1  ld_addr[31:2] matches a valid entry.
- ld_data  out  32  data of the youngest matching entry; 0 when no hit.
- dm_WE  out  1  write enable to DM.
- dm_adress  out  32  DM address: {entry addr[31:2], 2'b00}.
- dm_Wdata  out  32  DM write data.
- dm_pc  out  32  DM trace PC.
- empty  out  1  no valid entries.
- count  out  PTR_W+1  number of valid entries.

Behaviour:
- Storage and state:
  - Circular FIFO of DEPTH entries {addr[31:2], data[31:0], pc[31:0]}.
  - Head and tail pointers are PTR_W bits wide and wrap modulo DEPTH.
  - count is a separate register.
- Reset: asynchronous, active-low. On reset, head=0, tail=0, count=0, empty=1, dm_WE=0, ld_hit=0, ld_data=0, st_ready=1.
  - Entry payloads need not be cleared.
  - A reset mid-operation discards all buffered stores; nothing is written to DM.
- pop = !empty && !ld_req.
  - dm_WE = pop, combinational.
  - dm_adress, dm_Wdata and dm_pc always show the head entry, or 0 when empty.
  - DM performs the write at the same posedge; head advances at that edge.
- push = st_valid && st_ready.
  - st_ready = (count != DEPTH) || pop, so a push is allowed when full if a pop happens in the same cycle.
  - This creates a combinational path from ld_req to st_ready; that path is intentional.
- Count update per cycle:
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged, and both pointers advance.
- Full: when st_valid is high and st_ready is low, nothing is written.
  - The datapath must hold st_valid and its payload until accepted.
- Empty with push: the new entry is not drained in the same cycle.
  - The earliest dm_WE for it is the next cycle (1-cycle minimum latency).
- Lookup (combinational): compare ld_addr[31:2] against every valid entry.
  - ld_hit=1 if any entry matches; ld_data is taken from the youngest matching entry (closest to tail).
  - A store being pushed in the same cycle is not visible to lookup.
  - The head entry being popped in the same cycle is still visible to lookup.
- Lookup is independent of ld_req; the datapath qualifies ld_hit.
- Ordering: DM writes occur in exact program order; no store is dropped or duplicated.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined: if push and st_addr[31:2] equals the youngest entry's address, the store overwrites that entry's data and pc in place.
  - Conditions: the buffer is non-empty, and the youngest entry is not being popped this cycle.
  - In that case tail and count are unchanged.
  - When full, coalescing is allowed and st_ready=1.
- Not defined: every push allocates a new entry.

Decomposition:
- Shared package dm_sb_pkg holds:
  - the default DEPTH;
  - the entry typedef sb_entry_t {logic [29:0] waddr; logic [31:0] data; logic [31:0] pc;};
  - the address-to-word-index helper.
- One sub-module, dm_sb_lookup: a combinational youngest-match priority search over the entry array, valid mask and tail pointer. It outputs hit and data.

Test Plan:
- Reset and idle: assert rst=0 mid-run with 3 entries queued, then release. Required: count=0, empty=1, dm_WE=0, and no DM write of the queued data.
- Basic drain: push sw 0x10←0x1234 with ld_req=0. Required: next cycle dm_WE=1, dm_adress=0x10, dm_Wdata=0x1234, then empty=1.
- Backpressure: hold ld_req=1 and push 4 stores. Required: count=4 and st_ready=0; a 5th store is held.
  - Drop ld_req. Required: st_ready=1 in the same cycle; the 5th store is accepted while the head drains; count stays 4.
- Forwarding: with ld_req=1, push 0x20←A, 0x24←B, 0x20←C. Required: lookup 0x22 gives ld_hit=1 and ld_data=C; lookup 0x28 gives ld_hit=0 and ld_data=0.
- Ordering and wrap: 10 stores interleaved with random ld_req. Required: DM write sequence matches the push order exactly; pointers wrap past DEPTH−1.
- Coalesce (macro defined): ld_req=1, push 0x30←1 then 0x30←2. Required: count=1; after drain, a single DM write of 0x30←2. Without the macro: count=2 and two writes.
